// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Purpose  : ID/EX hazard inputs and stall/flush/MD outputs of the scoreboard
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_RegisterRs;
    logic [4:0]       ID_RegisterRt;
    logic [4:0]       ID_RegisterRd;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_RegWrite;
    logic             ID_MdOp;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRt;
    logic             EX_BranchTaken;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             MD_Busy;
    logic [4:0]       MD_Rd;
    logic             MD_Done;
    logic [CNT_W-1:0] StallCount;

    // Pipeline side: presents decoded ID/EX state, consumes control outputs.
    modport master (
        output ID_RegisterRs, ID_RegisterRt, ID_RegisterRd, ID_UsesRs, ID_UsesRt,
               ID_RegWrite, ID_MdOp, ID_EX_MemRead, ID_EX_RegisterRt, EX_BranchTaken,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy, MD_Rd,
               MD_Done, StallCount
    );

    modport slave (
        input  ID_RegisterRs, ID_RegisterRt, ID_RegisterRd, ID_UsesRs, ID_UsesRt,
               ID_RegWrite, ID_MdOp, ID_EX_MemRead, ID_EX_RegisterRt, EX_BranchTaken,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy, MD_Rd,
               MD_Done, StallCount
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Stall/flush controller for load-use, MUL/DIV and branch hazards
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input wire                 clk_i,
    input wire                 rst_i,
    hazard_scoreboard_if.slave sb
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;
    localparam logic [3:0] c_LAT_M1 = 4'(MD_LATENCY - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_stateNext;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cntNext;
    logic [4:0]       r_mdRd;
    logic [4:0]       w_mdRdNext;
    logic [CNT_W-1:0] r_stallCount;

    logic w_mdBusy;
    logic w_loadUse;
    logic w_mdRaw;
    logic w_mdWaw;
    logic w_mdStruct;
    logic w_stall;
    logic w_issue;
    logic w_countStall;

    // Register 0 is hardwired, so it never forms a dependency.
    function automatic logic srcHit(
        input logic [4:0] r,
        input logic       usesRs,
        input logic [4:0] rs,
        input logic       usesRt,
        input logic [4:0] rt
    );
        return (r != 5'd0) && ((usesRs && (rs == r)) || (usesRt && (rt == r)));
    endfunction

    assign w_mdBusy   = (r_state != c_IDLE);
    assign w_loadUse  = sb.ID_EX_MemRead &&
                        srcHit(sb.ID_EX_RegisterRt, sb.ID_UsesRs, sb.ID_RegisterRs,
                               sb.ID_UsesRt, sb.ID_RegisterRt);
    assign w_mdRaw    = w_mdBusy &&
                        srcHit(r_mdRd, sb.ID_UsesRs, sb.ID_RegisterRs,
                               sb.ID_UsesRt, sb.ID_RegisterRt);
    assign w_mdWaw    = w_mdBusy && sb.ID_RegWrite && (sb.ID_RegisterRd != 5'd0) &&
                        (sb.ID_RegisterRd == r_mdRd);
    assign w_mdStruct = w_mdBusy && sb.ID_MdOp;
    assign w_stall    = w_loadUse || w_mdRaw || w_mdWaw || w_mdStruct;
    assign w_issue    = sb.ID_MdOp && !w_stall && !sb.EX_BranchTaken && !w_mdBusy;
    assign w_countStall = w_stall && !sb.EX_BranchTaken;

    // A taken branch flushes the younger instructions, so any stall is moot.
    always_comb begin
        sb.PCWrite     = 1'b1;
        sb.IF_ID_Write = 1'b1;
        sb.IF_ID_Flush = 1'b0;
        sb.ID_EX_Flush = 1'b0;
        if (!rst_i) begin
            if (sb.EX_BranchTaken) begin
                sb.IF_ID_Flush = 1'b1;
                sb.ID_EX_Flush = 1'b1;
            end else if (w_stall) begin
                sb.PCWrite     = 1'b0;
                sb.IF_ID_Write = 1'b0;
                sb.ID_EX_Flush = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_mdRdNext  = r_mdRd;
        case (r_state)
            c_IDLE: begin
                if (w_issue) begin
                    w_stateNext = c_RUN;
                    w_cntNext   = c_LAT_M1;
                    w_mdRdNext  = sb.ID_RegisterRd;
                end
            end
            c_RUN: begin
                w_cntNext = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_stateNext = c_DONE;
                end
            end
            c_DONE: begin
                w_stateNext = c_IDLE;
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_mdRd       <= 5'd0;
            r_stallCount <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_mdRd  <= w_mdRdNext;
            if (w_countStall && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
        end
    end

    assign sb.MD_Busy    = w_mdBusy;
    assign sb.MD_Rd      = r_mdRd;
    assign sb.MD_Done    = (r_state == c_DONE);
    assign sb.StallCount = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   sc       = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(16)) ifA ();
    hazard_scoreboard_if #(.CNT_W(4))  ifS ();

    hazard_scoreboard #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (ifA)
    );

    hazard_scoreboard #(.MD_LATENCY(4), .CNT_W(4)) dutSat (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (ifS)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic [4:0] rs, input logic usesRs, input logic [4:0] rt,
                         input logic usesRt, input logic [4:0] rd, input logic regWrite,
                         input logic mdOp);
        ifA.ID_RegisterRs = rs;
        ifA.ID_UsesRs     = usesRs;
        ifA.ID_RegisterRt = rt;
        ifA.ID_UsesRt     = usesRt;
        ifA.ID_RegisterRd = rd;
        ifA.ID_RegWrite   = regWrite;
        ifA.ID_MdOp       = mdOp;
    endtask

    task automatic setEx(input logic memRead, input logic [4:0] exRt, input logic br);
        ifA.ID_EX_MemRead    = memRead;
        ifA.ID_EX_RegisterRt = exRt;
        ifA.EX_BranchTaken   = br;
    endtask

    task automatic clrA();
        setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        setEx(1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        clrA();
        ifS.ID_RegisterRs    = 5'd0;
        ifS.ID_UsesRs        = 1'b0;
        ifS.ID_RegisterRt    = 5'd0;
        ifS.ID_UsesRt        = 1'b0;
        ifS.ID_RegisterRd    = 5'd0;
        ifS.ID_RegWrite      = 1'b0;
        ifS.ID_MdOp          = 1'b0;
        ifS.ID_EX_MemRead    = 1'b0;
        ifS.ID_EX_RegisterRt = 5'd0;
        ifS.EX_BranchTaken   = 1'b0;
        tick();
        tick();

        // Reset forces pass-through controls even with a hazard present.
        setEx(1'b1, 5'd5, 1'b0);
        setId(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("rst_pcwrite", ifA.PCWrite, 1);
        chk("rst_ifidwrite", ifA.IF_ID_Write, 1);
        chk("rst_idexflush", ifA.ID_EX_Flush, 0);
        chk("rst_ifidflush", ifA.IF_ID_Flush, 0);
        chk("rst_busy", ifA.MD_Busy, 0);
        chk("rst_done", ifA.MD_Done, 0);
        tick();
        chk("rst_stallcount", ifA.StallCount, 0);
        rst = 1'b0;

        // Load-use: one stall cycle
        #1;
        chk("lu_pcwrite", ifA.PCWrite, 0);
        chk("lu_ifidwrite", ifA.IF_ID_Write, 0);
        chk("lu_idexflush", ifA.ID_EX_Flush, 1);
        chk("lu_ifidflush", ifA.IF_ID_Flush, 0);
        tick();
        sc = 1;
        setEx(1'b0, 5'd5, 1'b0);
        #1;
        chk("lu_release_pcwrite", ifA.PCWrite, 1);
        chk("lu_release_flush", ifA.ID_EX_Flush, 0);
        chk("lu_count", ifA.StallCount, sc);
        tick();
        setEx(1'b1, 5'd0, 1'b0);
        setId(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("lu_r0_nostall", ifA.PCWrite, 1);
        tick();
        setEx(1'b1, 5'd5, 1'b0);
        setId(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("lu_norsuse_nostall", ifA.PCWrite, 1);
        setId(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("lu_rt_stall", ifA.PCWrite, 0);
        tick();
        sc = 2;
        clrA();
        #1;
        chk("lu_count2", ifA.StallCount, sc);

        // MD RAW: issue mult r8, consumer of r8 stalls through DONE
        setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        #1;
        chk("raw_issue_pcwrite", ifA.PCWrite, 1);
        chk("raw_issue_busy", ifA.MD_Busy, 0);
        tick();
        setId(5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c == 1) chk("raw_mdrd", ifA.MD_Rd, 8);
            chk("raw_busy", ifA.MD_Busy, 1);
            chk("raw_pcwrite", ifA.PCWrite, 0);
            chk("raw_done", ifA.MD_Done, (c == 4) ? 1 : 0);
            tick();
        end
        sc += 4;
        #1;
        chk("raw_after_busy", ifA.MD_Busy, 0);
        chk("raw_after_pcwrite", ifA.PCWrite, 1);
        chk("raw_after_done", ifA.MD_Done, 0);
        chk("raw_count", ifA.StallCount, sc);
        tick();
        clrA();

        // Structural: second MD op held until the cycle after DONE
        setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        #1;
        tick();
        setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("struct_pcwrite", ifA.PCWrite, 0);
            chk("struct_done", ifA.MD_Done, (c == 4) ? 1 : 0);
            tick();
        end
        sc += 4;
        #1;
        chk("struct_issue_busy", ifA.MD_Busy, 0);
        chk("struct_issue_pcwrite", ifA.PCWrite, 1);
        tick();

        // WAW: ADD writing r10 behind the MD op to r10
        setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        for (int c = 6; c <= 9; c++) begin
            #1;
            if (c == 6) chk("waw_mdrd", ifA.MD_Rd, 10);
            chk("waw_busy", ifA.MD_Busy, 1);
            chk("waw_pcwrite", ifA.PCWrite, 0);
            chk("waw_done", ifA.MD_Done, (c == 9) ? 1 : 0);
            tick();
        end
        sc += 4;
        #1;
        chk("waw_after_pcwrite", ifA.PCWrite, 1);
        chk("waw_after_busy", ifA.MD_Busy, 0);
        chk("waw_count", ifA.StallCount, sc);
        tick();
        clrA();

        // Branch beats load-use and MD issue
        setEx(1'b1, 5'd5, 1'b1);
        setId(5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        #1;
        chk("br_ifidflush", ifA.IF_ID_Flush, 1);
        chk("br_idexflush", ifA.ID_EX_Flush, 1);
        chk("br_pcwrite", ifA.PCWrite, 1);
        chk("br_ifidwrite", ifA.IF_ID_Write, 1);
        tick();
        clrA();
        #1;
        chk("br_noissue", ifA.MD_Busy, 0);
        chk("br_count", ifA.StallCount, sc);

        // Branch does not cancel an issued MD op
        setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        #1;
        tick();
        setEx(1'b0, 5'd0, 1'b1);
        setId(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("brmd_pcwrite", ifA.PCWrite, 1);
        chk("brmd_idexflush", ifA.ID_EX_Flush, 1);
        tick();
        clrA();
        for (int c = 2; c <= 4; c++) begin
            #1;
            chk("brmd_done", ifA.MD_Done, (c == 4) ? 1 : 0);
            tick();
        end
        #1;
        chk("brmd_count", ifA.StallCount, sc);

        // Reset in cycle 2 of an MD op discards it
        setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        #1;
        tick();
        clrA();
        #1;
        tick();
        rst = 1'b1;
        setId(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("rstmd_pcwrite", ifA.PCWrite, 1);
        chk("rstmd_ifidwrite", ifA.IF_ID_Write, 1);
        chk("rstmd_idexflush", ifA.ID_EX_Flush, 0);
        tick();
        rst = 1'b0;
        clrA();
        #1;
        chk("rstmd_busy", ifA.MD_Busy, 0);
        chk("rstmd_mdrd", ifA.MD_Rd, 0);
        chk("rstmd_count", ifA.StallCount, 0);
        chk("rstmd_sat_count", ifS.StallCount, 0);
        for (int c = 0; c < 6; c++) begin
            chk("rstmd_nodone", ifA.MD_Done, 0);
            tick();
        end

        // Saturation on the 4-bit counter
        ifS.ID_EX_MemRead    = 1'b1;
        ifS.ID_EX_RegisterRt = 5'd3;
        ifS.ID_RegisterRs    = 5'd3;
        ifS.ID_UsesRs        = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (i == 1) chk("sat_pcwrite", ifS.PCWrite, 0);
            tick();
            if (i == 10) chk("sat_mid", ifS.StallCount, 10);
        end
        chk("sat_hold", ifS.StallCount, 15);
        ifS.ID_EX_MemRead = 1'b0;
        ifS.ID_UsesRs     = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
